// File: rtl/i2c_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cmd_sequencer
//
// Command front-end for i2c_master. A host pushes I2C transactions
// (7-bit address, rw, write byte) into a small FIFO. The sequencer issues them
// to the master one at a time over its enable/ready handshake. It returns
// exactly one in-order response per command, carrying either the read byte or
// a timeout flag.
//
// Parameters
//   PTR_W    FIFO pointer width; the FIFO holds 2**PTR_W commands
//   TIMEOUT  clk cycles allowed from launch to completion
//   TO_W     timeout counter width; 2**TO_W must exceed TIMEOUT
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   cmd_valid/cmd_ready       host command handshake
//   cmd_addr/cmd_rw/cmd_wdata command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready       response handshake (held until accepted)
//   rsp_rw/rsp_rdata          rw and read byte of the completed command
//   rsp_timeout               command did not complete in time
//   m_enable/m_addr/m_rw/
//   m_data_in                 request to i2c_master (all registered)
//   m_data_out/m_ready        result and idle flag from i2c_master
//   busy                      sequencer is not idle
//   fifo_count                commands currently queued
// -----------------------------------------------------------------------------
module i2c_cmd_sequencer #(
  parameter int PTR_W   = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [7:0]       cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_rw,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_timeout,
  output logic             m_enable,
  output logic [6:0]       m_addr,
  output logic             m_rw,
  output logic [7:0]       m_data_in,
  input  logic [7:0]       m_data_out,
  input  logic             m_ready,
  output logic             busy,
  output logic [PTR_W:0]   fifo_count
);

  localparam int                DEPTH   = 2 ** PTR_W;
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_DONE,
    ST_RESPOND
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             push;
  logic             pop;
  cmd_t             head;

  state_t           state_q;

  assign cmd_ready  = (count_q != DEPTH_C);
  assign push       = cmd_valid && cmd_ready;
  // The only place a command leaves the FIFO is the IDLE->LAUNCH step, so the
  // pop condition is exactly the FSM's launch condition.
  assign pop        = (state_q == ST_IDLE) && (count_q != '0) && m_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are exactly PTR_W bits wide, so they wrap mod DEPTH for free.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are valid, so clearing the data would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_rw, cmd_wdata};
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt_q;
  logic            m_enable_q;
  logic [6:0]      m_addr_q;
  logic            m_rw_q;
  logic [7:0]      m_data_in_q;
  logic            rsp_valid_q;
  logic            rsp_rw_q;
  logic [7:0]      rsp_rdata_q;
  logic            rsp_timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= '0;
      m_enable_q    <= 1'b0;
      m_addr_q      <= '0;
      m_rw_q        <= 1'b0;
      m_data_in_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            // Request fields stay frozen until the next pop.
            m_addr_q    <= head.addr;
            m_rw_q      <= head.rw;
            m_data_in_q <= head.wdata;
            m_enable_q  <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= ST_LAUNCH;
          end
        end

        ST_LAUNCH, ST_WAIT_DONE: begin
          // Timeout is tested first so it wins over a same-cycle completion.
          if (to_cnt_q == TO_LAST) begin
            m_enable_q    <= 1'b0;
            rsp_rw_q      <= m_rw_q;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESPOND;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (state_q == ST_LAUNCH) begin
              // The master runs on a divided clock; it signals acceptance by
              // dropping ready some clk cycles after enable rises.
              if (!m_ready) begin
                m_enable_q <= 1'b0;
                state_q    <= ST_WAIT_DONE;
              end
            end else if (m_ready) begin
              rsp_rw_q      <= m_rw_q;
              rsp_rdata_q   <= m_rw_q ? m_data_out : 8'h00;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= ST_RESPOND;
            end
          end
        end

        ST_RESPOND: begin
          // Response is held indefinitely; nothing launches until it is taken.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign m_enable    = m_enable_q;
  assign m_addr      = m_addr_q;
  assign m_rw        = m_rw_q;
  assign m_data_in   = m_data_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rw      = rsp_rw_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_i2c_cmd_sequencer
//
// Directed bench for i2c_cmd_sequencer (DEPTH=4, TIMEOUT=16). A behavioural
// i2c_master stand-in accepts a launch 3 clk after enable and completes 6 clk
// later, returning the byte stored for the addressed slave. It can be frozen
// busy (ready low) or dead (ready stuck high).
// -----------------------------------------------------------------------------
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_rw;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       m_enable;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_in;
  logic [7:0] m_data_out;
  logic       m_ready;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic       master_dead = 1'b0;
  logic       force_busy  = 1'b0;
  logic [7:0] slave_mem [128];

  i2c_cmd_sequencer #(.PTR_W(2), .TIMEOUT(16), .TO_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_rw      (cmd_rw),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rw      (rsp_rw),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .m_enable    (m_enable),
    .m_addr      (m_addr),
    .m_rw        (m_rw),
    .m_data_in   (m_data_in),
    .m_data_out  (m_data_out),
    .m_ready     (m_ready),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Master stand-in: reacts to enable seen 1 time unit after a clk edge.
  initial begin : master_model
    m_ready    = 1'b1;
    m_data_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!m_enable || master_dead || rst) begin
        m_ready = !force_busy;
      end else begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        m_data_out = slave_mem[m_addr];
        m_ready    = 1'b1;
      end
    end
  end

  // Presents one command and holds it until a clk edge accepts it.
  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rw    = rw;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for a response, checks it, then accepts it with a one-cycle ready.
  task automatic take_rsp(input string tag, input logic exp_rw, input logic [7:0] exp_rdata,
                          input logic exp_to);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"},   rsp_valid,   1);
    check({tag, "_rw"},      rsp_rw,      exp_rw);
    check({tag, "_rdata"},   rsp_rdata,   exp_rdata);
    check({tag, "_timeout"}, rsp_timeout, exp_to);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, "_release"}, rsp_valid, 0);
  endtask

  task automatic wait_enable(input string tag);
    int n = 0;
    @(negedge clk);
    while (!m_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_enable"}, m_enable, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int bad;

    for (int i = 0; i < 128; i++) slave_mem[i] = 8'hEE;

    // ---------------- Reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",  cmd_ready,  1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy",       busy,       0);
    check("rst_m_enable",   m_enable,   0);
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_m_addr",     m_addr,     0);
    check("rst_rsp_rdata",  rsp_rdata,  0);
    rst = 1'b0;

    // ---------------- Single write ----------------
    push_cmd(7'h50, 1'b0, 8'hA5);
    check("wr_queued", fifo_count, 1);
    check("wr_no_launch_yet", m_enable, 0);
    @(posedge clk);
    #1;
    check("wr_launch_enable", m_enable, 1);
    check("wr_popped", fifo_count, 0);
    check("wr_busy", busy, 1);
    check("wr_m_addr", m_addr, 7'h50);
    check("wr_m_rw", m_rw, 0);
    check("wr_m_data_in", m_data_in, 8'hA5);
    n = 0;
    while (m_ready !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wr_accepted", m_ready, 0);
    n = 0;
    while (m_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wr_done", m_ready, 1);
    check("wr_enable_dropped", m_enable, 0);
    check("wr_rsp_not_early", rsp_valid, 0);
    @(negedge clk);
    check("wr_rsp_one_clk", rsp_valid, 1);
    check("wr_m_addr_held", m_addr, 7'h50);
    take_rsp("wr", 1'b0, 8'h00, 1'b0);

    // ---------------- Single read ----------------
    slave_mem[7'h68] = 8'h3C;
    push_cmd(7'h68, 1'b1, 8'h00);
    take_rsp("rd", 1'b1, 8'h3C, 1'b0);

    // ---------------- Five commands, FIFO full ----------------
    slave_mem[7'h10] = 8'h11;
    slave_mem[7'h12] = 8'h33;
    slave_mem[7'h13] = 8'h44;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    push_cmd(7'h10, 1'b1, 8'h00);
    push_cmd(7'h11, 1'b0, 8'h22);
    push_cmd(7'h12, 1'b1, 8'h00);
    push_cmd(7'h13, 1'b1, 8'h00);
    check("full_count", fifo_count, 4);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_no_launch", busy, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 7'h14;
    cmd_rw    = 1'b0;
    cmd_wdata = 8'h55;
    repeat (3) @(negedge clk);
    check("full_not_written", fifo_count, 4);
    force_busy = 1'b0;
    n = 0;
    while (!m_enable && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("full_first_pop", fifo_count, 3);
    check("full_ready_after_pop", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("full_fifth_accepted", fifo_count, 4);
    take_rsp("q0", 1'b1, 8'h11, 1'b0);
    take_rsp("q1", 1'b0, 8'h00, 1'b0);
    take_rsp("q2", 1'b1, 8'h33, 1'b0);
    take_rsp("q3", 1'b1, 8'h44, 1'b0);
    take_rsp("q4", 1'b0, 8'h00, 1'b0);
    check("q4_m_addr", m_addr, 7'h14);
    check("q4_m_data_in", m_data_in, 8'h55);
    check("q_empty", fifo_count, 0);

    // ---------------- Timeout with dead master ----------------
    master_dead = 1'b1;
    slave_mem[7'h22] = 8'h99;
    push_cmd(7'h22, 1'b1, 8'h00);
    wait_enable("to");
    repeat (15) @(negedge clk);
    check("to_not_early", rsp_valid, 0);
    check("to_enable_held", m_enable, 1);
    @(negedge clk);
    check("to_at_16", rsp_valid, 1);
    check("to_enable_dropped", m_enable, 0);
    take_rsp("to", 1'b1, 8'h00, 1'b1);
    master_dead = 1'b0;
    push_cmd(7'h68, 1'b1, 8'h00);
    take_rsp("after_to", 1'b1, 8'h3C, 1'b0);

    // ---------------- Response back-pressure ----------------
    slave_mem[7'h30] = 8'h77;
    push_cmd(7'h30, 1'b1, 8'h00);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_rsp_up", rsp_valid, 1);
    push_cmd(7'h40, 1'b0, 8'h01);
    push_cmd(7'h41, 1'b0, 8'h02);
    push_cmd(7'h42, 1'b0, 8'h03);
    push_cmd(7'h43, 1'b0, 8'h04);
    check("hold_fifo_full", fifo_count, 4);
    check("hold_cmd_ready", cmd_ready, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rw !== 1'b1 || rsp_rdata !== 8'h77 ||
          rsp_timeout !== 1'b0 || m_enable !== 1'b0 || fifo_count !== 3'd4)
        bad++;
    end
    check("hold_stable_cycles_bad", bad, 0);
    take_rsp("hold", 1'b1, 8'h77, 1'b0);

    // ---------------- Reset in WAIT_DONE with 3 queued ----------------
    n = 0;
    while (m_ready !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rst_wd_busy", busy, 1);
    check("rst_wd_enable_low", m_enable, 0);
    check("rst_wd_queued", fifo_count, 3);
    #2 rst = 1'b1;
    #1;
    check("rst_wd_m_enable", m_enable, 0);
    check("rst_wd_fifo_count", fifo_count, 0);
    check("rst_wd_rsp_valid", rsp_valid, 0);
    check("rst_wd_cmd_ready", cmd_ready, 1);
    check("rst_wd_idle", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || m_enable !== 1'b0) bad++;
    end
    check("rst_wd_no_response", bad, 0);

    // ---------------- Reset in LAUNCH drops enable at once ----------------
    push_cmd(7'h05, 1'b0, 8'h66);
    wait_enable("rst_ln");
    #2 rst = 1'b1;
    #1;
    check("rst_ln_m_enable", m_enable, 0);
    check("rst_ln_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
